// File: rtl/block_pair_framer.sv
// block_pair_framer
// Collects a byte stream into (message, key) block pairs and presents each
// completed pair on a valid/ready output. Bytes are packed big-endian: the
// first byte accepted for a block lands in its most significant byte.
//
// Ports:
//   clk, reset          - clock and synchronous active-high reset
//   in_byte/in_valid    - input byte stream
//   in_ready            - a byte is accepted this cycle when in_valid is high
//   msg, key            - last completed message/key pair (8*BLOCK_BYTES bits each)
//   out_valid/out_ready - output pair handshake
//   byte_idx            - index of the next byte within the current block
//   in_key              - high while the key block is being collected
//   frame_cnt           - completed pair count, wraps at 16 bits
//   timeout_pulse       - one-cycle pulse when a partial frame is discarded
//
// Optional feature: define FRAMER_TIMEOUT_EN to build the idle-gap counter
// that discards a partial frame after TIMEOUT_CYCLES idle clocks. Without it
// a partial frame waits indefinitely and timeout_pulse is tied low.

module block_pair_framer #(
    parameter int unsigned BLOCK_BYTES    = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [7:0]                     in_byte,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [8*BLOCK_BYTES-1:0]       msg,
    output logic [8*BLOCK_BYTES-1:0]       key,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [$clog2(BLOCK_BYTES)-1:0] byte_idx,
    output logic                           in_key,
    output logic [15:0]                    frame_cnt,
    output logic                           timeout_pulse
);

    localparam int unsigned W     = 8 * BLOCK_BYTES;
    localparam int unsigned WW    = 2 * W;
    localparam int unsigned IDX_W = $clog2(BLOCK_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_BYTES - 1);

    typedef enum logic [1:0] {
        ST_MSG  = 2'd0,
        ST_KEY  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [IDX_W-1:0] idx_next;
    logic [WW-1:0]    work, work_next;
    logic [W-1:0]     msg_next, key_next;
    logic             out_valid_next;
    logic [15:0]      frame_cnt_next;
    logic             in_key_next;
    logic             accept;

`ifdef FRAMER_TIMEOUT_EN
    localparam int unsigned GAP_W = 24;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);

    logic [GAP_W-1:0] gap, gap_next;
    logic             gap_run;
    logic             pulse_next;
`endif

    // Ready in both collecting states; never while reset is asserted.
    assign in_ready = !reset && (state != ST_HOLD);
    assign accept   = in_valid && in_ready;

    // Next-state and next-register values.
    always_comb begin
        state_next     = state;
        idx_next       = byte_idx;
        work_next      = work;
        msg_next       = msg;
        key_next       = key;
        out_valid_next = out_valid;
        frame_cnt_next = frame_cnt;
`ifdef FRAMER_TIMEOUT_EN
        gap_next       = gap;
        gap_run        = 1'b0;
        pulse_next     = 1'b0;
`endif

        case (state)
            ST_MSG, ST_KEY: begin
                if (accept) begin
                    // One 2W-bit shift register holds msg (upper) then key (lower).
                    work_next = {work[WW-9:0], in_byte};
                    if (byte_idx == LAST_IDX) begin
                        idx_next = '0;
                        if (state == ST_MSG) begin
                            state_next = ST_KEY;
                        end else begin
                            state_next     = ST_HOLD;
                            msg_next       = work_next[WW-1:W];
                            key_next       = work_next[W-1:0];
                            out_valid_next = 1'b1;
                            frame_cnt_next = frame_cnt + 16'd1;
                        end
                    end else begin
                        idx_next = byte_idx + IDX_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_next     = ST_MSG;
                    out_valid_next = 1'b0;
                end
            end
            default: begin
                state_next = ST_MSG;
            end
        endcase

`ifdef FRAMER_TIMEOUT_EN
        // Gap counter runs only while a frame is partially collected; an
        // accepted byte always wins over an expiring count.
        gap_run = ((state == ST_MSG) && (byte_idx != '0)) || (state == ST_KEY);
        if (accept) begin
            gap_next = '0;
        end else if (gap_run) begin
            if (gap == GAP_LAST) begin
                state_next = ST_MSG;
                idx_next   = '0;
                work_next  = '0;
                gap_next   = '0;
                pulse_next = 1'b1;
            end else begin
                gap_next = gap + GAP_W'(1);
            end
        end else begin
            gap_next = '0;
        end
`endif

        in_key_next = (state_next == ST_KEY);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_MSG;
            byte_idx  <= '0;
            work      <= '0;
            msg       <= '0;
            key       <= '0;
            out_valid <= 1'b0;
            frame_cnt <= '0;
            in_key    <= 1'b0;
        end else begin
            state     <= state_next;
            byte_idx  <= idx_next;
            work      <= work_next;
            msg       <= msg_next;
            key       <= key_next;
            out_valid <= out_valid_next;
            frame_cnt <= frame_cnt_next;
            in_key    <= in_key_next;
        end
    end

`ifdef FRAMER_TIMEOUT_EN
    // Idle-gap counter and discard pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            gap           <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            gap           <= gap_next;
            timeout_pulse <= pulse_next;
        end
    end
`else
    assign timeout_pulse = 1'b0;
`endif

endmodule
